// File: rtl/sample_packer.sv
// Packs 1-4 byte compacted samples little-endian into dense 32-bit words; optional word counter via SAMPLE_PACKER_COUNT_EN.
// Latency 1 clock from completing sample to word; at most one word per cycle, so no backpressure is needed.
module sample_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         COUNT_W  = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3:0]         disabledGroups,
  input  logic               clear,
  input  logic               flush,
  input  logic               validIn,
  input  logic [31:0]        dataIn,
  output logic               validOut,
  output logic [31:0]        dataOut,
  output logic               flushDone
`ifdef SAMPLE_PACKER_COUNT_EN
  ,
  output logic [COUNT_W-1:0] wordCount
`endif
);

  logic [55:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;

  logic [2:0]  pop;
  logic [2:0]  n_bytes;
  logic [3:0]  in_mask;
  logic [3:0]  res_mask;
  logic [31:0] in_bytes;
  logic [55:0] merged;
  logic [2:0]  tot;
  logic        full;
  logic        flush_req;
  logic [31:0] pad_word;

  always_comb begin
    pop = {2'b00, disabledGroups[0]} + {2'b00, disabledGroups[1]}
        + {2'b00, disabledGroups[2]} + {2'b00, disabledGroups[3]};
    // All groups disabled is treated like all enabled.
    case (pop)
      3'd1:    n_bytes = 3'd3;
      3'd2:    n_bytes = 3'd2;
      3'd3:    n_bytes = 3'd1;
      default: n_bytes = 3'd4;
    endcase
    case (n_bytes)
      3'd1:    in_mask = 4'b0001;
      3'd2:    in_mask = 4'b0011;
      3'd3:    in_mask = 4'b0111;
      default: in_mask = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) begin
      in_bytes[i*8 +: 8] = in_mask[i] ? dataIn[i*8 +: 8] : 8'h00;
    end

    if (validIn) begin
      merged = buf_q | ({24'b0, in_bytes} << {cnt_q, 3'b000});
      tot    = cnt_q + n_bytes;
    end else begin
      merged = buf_q;
      tot    = cnt_q;
    end
    full      = validIn && (tot >= 3'd4);
    flush_req = flush || pend_q;

    case (tot[1:0])
      2'd1:    res_mask = 4'b0001;
      2'd2:    res_mask = 4'b0011;
      2'd3:    res_mask = 4'b0111;
      default: res_mask = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      pad_word[i*8 +: 8] = res_mask[i] ? merged[i*8 +: 8] : PAD_BYTE;
    end
  end

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    valid_d = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    if (clear) begin
      buf_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (full) begin
      // A full word takes the output slot; any flush waits for a free cycle.
      valid_d = 1'b1;
      data_d  = merged[31:0];
      buf_d   = {32'b0, merged[55:32]};
      cnt_d   = tot - 3'd4;
      pend_d  = flush_req;
    end else if (flush_req) begin
      pend_d = 1'b0;
      done_d = 1'b1;
      buf_d  = '0;
      cnt_d  = '0;
      if (tot != 3'd0) begin
        valid_d = 1'b1;
        data_d  = pad_word;
      end
    end else begin
      buf_d = merged;
      cnt_d = tot;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign validOut  = valid_q;
  assign dataOut   = data_q;
  assign flushDone = done_q;

`ifdef SAMPLE_PACKER_COUNT_EN
  logic [COUNT_W-1:0] words_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      words_q <= '0;
    end else if (clear) begin
      words_q <= '0;
    end else if (valid_d) begin
      words_q <= words_q + COUNT_W'(1);
    end
  end

  assign wordCount = words_q;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Directed-vector bench for sample_packer; build with SAMPLE_PACKER_COUNT_EN to also cover wordCount.
module tb_sample_packer;

  logic        clock;
  logic        reset_n;
  logic [3:0]  disabledGroups;
  logic        clear;
  logic        flush;
  logic        validIn;
  logic [31:0] dataIn;
  logic        validOut;
  logic [31:0] dataOut;
  logic        flushDone;
`ifdef SAMPLE_PACKER_COUNT_EN
  logic [31:0] wordCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sample_packer #(.PAD_BYTE(8'h00), .COUNT_W(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .disabledGroups (disabledGroups),
    .clear          (clear),
    .flush          (flush),
    .validIn        (validIn),
    .dataIn         (dataIn),
    .validOut       (validOut),
    .dataOut        (dataOut),
    .flushDone      (flushDone)
`ifdef SAMPLE_PACKER_COUNT_EN
    ,
    .wordCount      (wordCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample the registered outputs 1 ns after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic f, input logic c);
    validIn = v;
    dataIn  = d;
    flush   = f;
    clear   = c;
    @(posedge clock);
    #1;
    validIn = 1'b0;
    dataIn  = 32'h0;
    flush   = 1'b0;
    clear   = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    disabledGroups = 4'b0000;
    clear          = 1'b0;
    flush          = 1'b0;
    validIn        = 1'b0;
    dataIn         = 32'h0;
    #22;
    check("rst_valid", {31'b0, validOut}, 32'h0);
    check("rst_data", dataOut, 32'h0);
    check("rst_done", {31'b0, flushDone}, 32'h0);
`ifdef SAMPLE_PACKER_COUNT_EN
    check("rst_count", wordCount, 32'h0);
`endif
    reset_n = 1'b1;

    // N=3: four samples give three words with bytes carried across words
    disabledGroups = 4'b1000;
    step(1'b1, 32'h00CCBBAA, 1'b0, 1'b0);
    check("n3_s0_valid", {31'b0, validOut}, 32'h0);
    step(1'b1, 32'h00FFEEDD, 1'b0, 1'b0);
    check("n3_w0_valid", {31'b0, validOut}, 32'h1);
    check("n3_w0_data", dataOut, 32'hDDCCBBAA);
    step(1'b1, 32'h00332211, 1'b0, 1'b0);
    check("n3_w1_valid", {31'b0, validOut}, 32'h1);
    check("n3_w1_data", dataOut, 32'h2211FFEE);
    step(1'b1, 32'h00665544, 1'b0, 1'b0);
    check("n3_w2_valid", {31'b0, validOut}, 32'h1);
    check("n3_w2_data", dataOut, 32'h66554433);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("n3_empty_flush_valid", {31'b0, validOut}, 32'h0);
    check("n3_empty_flush_done", {31'b0, flushDone}, 32'h1);

    // N=1: four bytes per word, then a padded flush
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("clr_valid", {31'b0, validOut}, 32'h0);
    check("clr_done", {31'b0, flushDone}, 32'h0);
    disabledGroups = 4'b1110;
    step(1'b1, 32'h00000011, 1'b0, 1'b0);
    step(1'b1, 32'h00000022, 1'b0, 1'b0);
    step(1'b1, 32'h00000033, 1'b0, 1'b0);
    check("n1_s2_valid", {31'b0, validOut}, 32'h0);
    step(1'b1, 32'h00000044, 1'b0, 1'b0);
    check("n1_w0_valid", {31'b0, validOut}, 32'h1);
    check("n1_w0_data", dataOut, 32'h44332211);
    step(1'b1, 32'h00000055, 1'b0, 1'b0);
    check("n1_s4_valid", {31'b0, validOut}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("n1_flush_valid", {31'b0, validOut}, 32'h1);
    check("n1_flush_data", dataOut, 32'h00000055);
    check("n1_flush_done", {31'b0, flushDone}, 32'h1);
`ifdef SAMPLE_PACKER_COUNT_EN
    check("n1_count", wordCount, 32'h2);
`endif

    // N=4: pass-through, flush with nothing buffered
    step(1'b0, 32'h0, 1'b0, 1'b1);
    disabledGroups = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hA5000000 + 32'(i * 32'h00010203), 1'b0, 1'b0);
      check("n4_valid", {31'b0, validOut}, 32'h1);
      check("n4_data", dataOut, 32'hA5000000 + 32'(i * 32'h00010203));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("n4_flush_valid", {31'b0, validOut}, 32'h0);
    check("n4_flush_done", {31'b0, flushDone}, 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("n4_idle_valid", {31'b0, validOut}, 32'h0);
    check("n4_idle_done", {31'b0, flushDone}, 32'h0);

    // N=3: flush arriving with a word-completing sample is deferred one cycle
    step(1'b0, 32'h0, 1'b0, 1'b1);
    disabledGroups = 4'b1000;
    step(1'b1, 32'h00CCBBAA, 1'b0, 1'b0);
    step(1'b1, 32'h00FFEEDD, 1'b1, 1'b0);
    check("defer_w_valid", {31'b0, validOut}, 32'h1);
    check("defer_w_data", dataOut, 32'hDDCCBBAA);
    check("defer_w_done", {31'b0, flushDone}, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("defer_f_valid", {31'b0, validOut}, 32'h1);
    check("defer_f_data", dataOut, 32'h0000FFEE);
    check("defer_f_done", {31'b0, flushDone}, 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("defer_idle_valid", {31'b0, validOut}, 32'h0);
    check("defer_idle_done", {31'b0, flushDone}, 32'h0);

    // N=2: clear discards residue
    step(1'b0, 32'h0, 1'b0, 1'b1);
    disabledGroups = 4'b1100;
    step(1'b1, 32'h0000BBAA, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("n2_clr_valid", {31'b0, validOut}, 32'h0);
    check("n2_clr_done", {31'b0, flushDone}, 32'h0);
    step(1'b1, 32'h00002211, 1'b0, 1'b0);
    check("n2_s0_valid", {31'b0, validOut}, 32'h0);
    step(1'b1, 32'h00004433, 1'b0, 1'b0);
    check("n2_w_valid", {31'b0, validOut}, 32'h1);
    check("n2_w_data", dataOut, 32'h44332211);

    // Asynchronous reset while a word is on the output and residue is buffered
    step(1'b0, 32'h0, 1'b0, 1'b1);
    disabledGroups = 4'b1000;
    step(1'b1, 32'h00CCBBAA, 1'b0, 1'b0);
    step(1'b1, 32'h00FFEEDD, 1'b0, 1'b0);
    check("pre_rst_valid", {31'b0, validOut}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, validOut}, 32'h0);
    check("arst_data", dataOut, 32'h0);
    check("arst_done", {31'b0, flushDone}, 32'h0);
`ifdef SAMPLE_PACKER_COUNT_EN
    check("arst_count", wordCount, 32'h0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 32'h00332211, 1'b0, 1'b0);
    check("post_rst_s0_valid", {31'b0, validOut}, 32'h0);
    step(1'b1, 32'h00665544, 1'b0, 1'b0);
    check("post_rst_w_valid", {31'b0, validOut}, 32'h1);
    check("post_rst_w_data", dataOut, 32'h44332211);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
